shift_reg_seq: RTL

//  Parametrised successor to the single-bit D flip-flop. It is a WIDTH-bit universal register

---
 rtl/shift_reg_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/shift_reg_seq.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_seq
// Description : WIDTH-bit universal register (hold / load / shift left/right)
//               with complementary outputs and an N-shift burst sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_seq #(
    parameter int WIDTH  = 8,
    parameter bit ROTATE = 1'b0,
    parameter int CW     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic             start,
    input  logic             dir,
    input  logic [CW-1:0]    shift_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0]    c_mode_hold  = 2'b00;
    localparam logic [1:0]    c_mode_right = 2'b01;
    localparam logic [1:0]    c_mode_left  = 2'b10;
    localparam logic [1:0]    c_mode_load  = 2'b11;
    localparam logic [CW-1:0] c_cnt_one    = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qb;
    logic             r_dir;
    logic [CW-1:0]    r_cnt;
    logic             r_done;

    logic             w_in_right;
    logic             w_in_left;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_q_next;

    // Fill bits: recirculated end bit when rotating, otherwise the serial inputs.
    assign w_in_right = ROTATE ? r_q[0]       : sin_msb;
    assign w_in_left  = ROTATE ? r_q[WIDTH-1] : sin_lsb;
    assign w_shr      = {w_in_right, r_q[WIDTH-1:1]};
    assign w_shl      = {r_q[WIDTH-2:0], w_in_left};

    always_comb begin
        w_q_next = r_q;
        if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (!start) begin
                        case (mode)
                            c_mode_hold:  w_q_next = r_q;
                            c_mode_right: w_q_next = w_shr;
                            c_mode_left:  w_q_next = w_shl;
                            c_mode_load:  w_q_next = d;
                        endcase
                    end
                end
                S_SHIFT: begin
                    w_q_next = r_dir ? w_shl : w_shr;
                end
            endcase
        end
    end

    // qb is loaded from the same next value as q so the pair never diverges.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_qb    <= '1;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_qb   <= ~w_q_next;
            r_done <= 1'b0;
            if (en) begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (shift_cnt == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state <= S_SHIFT;
                                r_dir   <= dir;
                                r_cnt   <= shift_cnt;
                            end
                        end
                    end
                    S_SHIFT: begin
                        r_cnt <= r_cnt - c_cnt_one;
                        if (r_cnt == c_cnt_one) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign q        = r_q;
    assign qb       = r_qb;
    assign sout_lsb = r_q[0];
    assign sout_msb = r_q[WIDTH-1];
    assign busy     = (r_state == S_SHIFT);
    assign done     = r_done;

endmodule
`default_nettype wire
